// File: rtl/sys_bus_arbiter_pkg.sv
// Shared types and helpers for the system bus arbiter: FSM encoding,
// index widths and the round-robin pointer advance.
package sys_bus_arbiter_pkg;

  localparam int MAX_M = 4;
  localparam int IDX_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_e;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input int num_m);
    if (int'(idx) + 1 >= num_m) return '0;
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Requester and bus-target signals of the shared system bus arbiter.
// master: requesting masters; slave: the arbiter; target: the bus slave side.
interface sys_bus_arbiter_if #(
  parameter int NUM_M = 2
);
  logic [NUM_M-1:0]    m_req;
  logic [NUM_M-1:0]    m_lock;
  logic [32*NUM_M-1:0] m_addr;
  logic [32*NUM_M-1:0] m_wdata;
  logic [NUM_M-1:0]    m_rd;
  logic [4*NUM_M-1:0]  m_we;
  logic [NUM_M-1:0]    m_gnt;
  logic [NUM_M-1:0]    m_ack;
  logic [NUM_M-1:0]    m_err;
  logic [31:0]         m_rdata;
  logic [31:0]         bus_addr;
  logic [31:0]         bus_wdata;
  logic                bus_rd;
  logic [3:0]          bus_we;
  logic                bus_ready;
  logic [31:0]         bus_rdata;

  modport master (
    output m_req, m_lock, m_addr, m_wdata, m_rd, m_we,
    input  m_gnt, m_ack, m_err, m_rdata
  );

  modport slave (
    input  m_req, m_lock, m_addr, m_wdata, m_rd, m_we,
    output m_gnt, m_ack, m_err, m_rdata,
    output bus_addr, bus_wdata, bus_rd, bus_we,
    input  bus_ready, bus_rdata
  );

  modport target (
    input  bus_addr, bus_wdata, bus_rd, bus_we,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/sys_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module sys_bus_arbiter_rr_picker
  import sys_bus_arbiter_pkg::*;
#(
  parameter int NUM_M = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NUM_M-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx,
  output logic             valid
);

  logic [NUM_M-1:0] upper;
  logic [NUM_M-1:0] src;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_mask
      assign upper[gi] = req[gi] && (gi >= int'(ptr));
    end
  endgenerate

  // Requests at/after the pointer take precedence; otherwise wrap to the lowest.
  always_comb begin
    src        = (upper != '0) ? upper : req;
    win_onehot = '0;
    win_idx    = '0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (src[i]) begin
        win_idx    = IDX_W'(i);
        win_onehot = NUM_M'(1) << i;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/sys_bus_arbiter.sv
// Round-robin arbiter/sequencer for the shared system bus: one transfer at a
// time, registered bus outputs, ack/err pulses and a saturating timeout.
module sys_bus_arbiter
  import sys_bus_arbiter_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int TIMEOUT = 255,
  parameter int PARK_M  = 0
) (
  input  logic             clk,
  input  logic             rst,
  sys_bus_arbiter_if.slave bif,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  // Per-master fields padded to MAX_M so the owner index always fits exactly.
  logic [MAX_M-1:0] req_pad, lock_pad, rd_pad;
  logic [31:0]      addr_arr  [MAX_M];
  logic [31:0]      wdata_arr [MAX_M];
  logic [3:0]       we_arr    [MAX_M];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_M; gi++) begin : g_port
      if (gi < NUM_M) begin : g_used
        assign req_pad[gi]   = bif.m_req[gi];
        assign lock_pad[gi]  = bif.m_lock[gi];
        assign rd_pad[gi]    = bif.m_rd[gi];
        assign addr_arr[gi]  = bif.m_addr[gi*32 +: 32];
        assign wdata_arr[gi] = bif.m_wdata[gi*32 +: 32];
        assign we_arr[gi]    = bif.m_we[gi*4 +: 4];
      end else begin : g_unused
        assign req_pad[gi]   = 1'b0;
        assign lock_pad[gi]  = 1'b0;
        assign rd_pad[gi]    = 1'b0;
        assign addr_arr[gi]  = '0;
        assign wdata_arr[gi] = '0;
        assign we_arr[gi]    = '0;
      end
    end
  endgenerate

  arb_state_e       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [NUM_M-1:0] gnt_reg, gnt_next;
  logic [NUM_M-1:0] ack_reg, ack_next;
  logic [NUM_M-1:0] err_reg, err_next;
  logic [31:0]      rdata_reg, rdata_next;
  logic [31:0]      bus_addr_reg, bus_addr_next;
  logic [31:0]      bus_wdata_reg, bus_wdata_next;
  logic             bus_rd_reg, bus_rd_next;
  logic [3:0]       bus_we_reg, bus_we_next;

  logic [NUM_M-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  sys_bus_arbiter_rr_picker #(.NUM_M(NUM_M)) u_picker (
    .req        (bif.m_req),
    .ptr        (ptr_reg),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .valid      (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= IDX_W'(PARK_M);
      owner_reg     <= '0;
      cnt_reg       <= '0;
      gnt_reg       <= '0;
      ack_reg       <= '0;
      err_reg       <= '0;
      rdata_reg     <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      bus_rd_reg    <= 1'b0;
      bus_we_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      owner_reg     <= owner_next;
      cnt_reg       <= cnt_next;
      gnt_reg       <= gnt_next;
      ack_reg       <= ack_next;
      err_reg       <= err_next;
      rdata_reg     <= rdata_next;
      bus_addr_reg  <= bus_addr_next;
      bus_wdata_reg <= bus_wdata_next;
      bus_rd_reg    <= bus_rd_next;
      bus_we_reg    <= bus_we_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    owner_next     = owner_reg;
    cnt_next       = cnt_reg;
    gnt_next       = gnt_reg;
    ack_next       = '0;
    err_next       = '0;
    rdata_next     = rdata_reg;
    bus_addr_next  = bus_addr_reg;
    bus_wdata_next = bus_wdata_reg;
    bus_rd_next    = bus_rd_reg;
    bus_we_next    = bus_we_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_next = pick_idx;
          gnt_next   = pick_onehot;
          state_next = ST_GRANT;
        end
      end
      ST_GRANT: begin
        bus_addr_next  = addr_arr[owner_reg];
        bus_wdata_next = wdata_arr[owner_reg];
        bus_rd_next    = rd_pad[owner_reg];
        bus_we_next    = we_arr[owner_reg];
        cnt_next       = '0;
        state_next     = ST_XFER;
      end
      ST_XFER: begin
        // Ready is checked before the timeout so it wins on the expiry cycle.
        if (bif.bus_ready || (cnt_reg == TIMEOUT_CNT)) begin
          if (bif.bus_ready) begin
            ack_next = gnt_reg;
            if (bus_rd_reg) rdata_next = bif.bus_rdata;
          end else begin
            err_next = gnt_reg;
          end
          bus_rd_next = 1'b0;
          bus_we_next = '0;
          if (bif.bus_ready && lock_pad[owner_reg] && req_pad[owner_reg]) begin
            state_next = ST_GRANT;
          end else begin
            gnt_next   = '0;
            ptr_next   = next_idx(owner_reg, NUM_M);
            state_next = ST_IDLE;
          end
        end else if (cnt_reg != '1) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bif.m_gnt     = gnt_reg;
  assign bif.m_ack     = ack_reg;
  assign bif.m_err     = err_reg;
  assign bif.m_rdata   = rdata_reg;
  assign bif.bus_addr  = bus_addr_reg;
  assign bif.bus_wdata = bus_wdata_reg;
  assign bif.bus_rd    = bus_rd_reg;
  assign bif.bus_we    = bus_we_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Scoreboard bench for sys_bus_arbiter: two masters, a bus target with a
// programmable ready delay, completions checked in predicted order and cycle.
module tb_sys_bus_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic [3:0]  we;
    logic        lock;
  } mtx_t;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [1:0]  gnt;
    logic        busy;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  mtx_t mq0[$];
  mtx_t mq1[$];
  exp_t sb[$];

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          slave_delay = 0;
  int          xc = 0;
  int          base = 0;
  logic        prev_vis = 1'b0;
  logic [31:0] model_rdata = '0;

  sys_bus_arbiter_if #(.NUM_M(2)) bif ();

  sys_bus_arbiter #(.NUM_M(2), .TIMEOUT(4), .PARK_M(0)) dut (
    .clk  (clk),
    .rst  (rst),
    .bif  (bif.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic drive_masters();
    mtx_t t0, t1;
    t0 = '0;
    t1 = '0;
    if (mq0.size() != 0) t0 = mq0[0];
    if (mq1.size() != 0) t1 = mq1[0];
    bif.m_req   = {mq1.size() != 0, mq0.size() != 0};
    bif.m_lock  = {t1.lock, t0.lock};
    bif.m_addr  = {t1.addr, t0.addr};
    bif.m_wdata = {t1.wdata, t0.wdata};
    bif.m_rd    = {t1.rd, t0.rd};
    bif.m_we    = {t1.we, t0.we};
  endtask

  // One clock: check completions, advance masters, then update the target.
  task automatic step();
    exp_t e;
    logic vis;
    @(posedge clk);
    cyc++;
    #1;
    if (bif.m_ack != 2'b00 || bif.m_err != 2'b00) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'({bif.m_ack, bif.m_err}), 64'(0));
      end else begin
        e = sb.pop_front();
        chk("ack", 64'(bif.m_ack), 64'(e.ack));
        chk("err", 64'(bif.m_err), 64'(e.err));
        chk("rdata", 64'(bif.m_rdata), 64'(e.rdata));
        chk("gnt_after", 64'(bif.m_gnt), 64'(e.gnt));
        chk("busy_after", 64'(busy), 64'(e.busy));
        chk("strobes_drop", 64'({bif.bus_rd, bif.bus_we}), 64'(0));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
      if ((bif.m_ack[0] || bif.m_err[0]) && mq0.size() != 0) void'(mq0.pop_front());
      if ((bif.m_ack[1] || bif.m_err[1]) && mq1.size() != 0) void'(mq1.pop_front());
    end
    drive_masters();
    vis = bif.bus_rd || (bif.bus_we != 4'h0);
    if (vis) begin
      xc = prev_vis ? xc + 1 : 0;
      bif.bus_ready = (xc == slave_delay);
    end else begin
      bif.bus_ready = 1'b0;
    end
    prev_vis = vis;
    bif.bus_rdata = slave_data(bif.bus_addr);
  endtask

  // Queue a transfer for master m; exp_cyc < 0 means no completion is expected.
  task automatic add_tx(input int m, input logic [31:0] addr, input logic rd, input logic [3:0] we,
                        input logic lock, input logic err, input int exp_cyc);
    mtx_t t;
    exp_t e;
    logic [1:0] oh;
    oh = 2'(1 << m);
    t = '{addr: addr, wdata: addr ^ 32'hFFFF_0000, rd: rd, we: we, lock: lock};
    if (m == 0) mq0.push_back(t);
    else mq1.push_back(t);
    if (exp_cyc >= 0) begin
      if (rd && !err) model_rdata = slave_data(addr);
      e.ack   = err ? 2'b00 : oh;
      e.err   = err ? oh : 2'b00;
      e.rdata = model_rdata;
      e.gnt   = (lock && !err) ? oh : 2'b00;
      e.busy  = lock && !err;
      e.cyc   = exp_cyc;
      sb.push_back(e);
    end
  endtask

  task automatic run_done(input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || mq0.size() != 0 || mq1.size() != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_pending", 64'(sb.size() + mq0.size() + mq1.size()), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    mq0.delete();
    mq1.delete();
    drive_masters();
    step();
    step();
    chk({tag, "_gnt"}, 64'(bif.m_gnt), 64'(0));
    chk({tag, "_ackerr"}, 64'({bif.m_ack, bif.m_err}), 64'(0));
    chk({tag, "_rdata"}, 64'(bif.m_rdata), 64'(0));
    chk({tag, "_bus"}, 64'({bif.bus_addr, bif.bus_rd, bif.bus_we}), 64'(0));
    chk({tag, "_wdata"}, 64'(bif.bus_wdata), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'(0));
    sb.delete();
    model_rdata = '0;
    rst = 1'b0;
  endtask

  initial begin
    bif.bus_ready = 1'b0;
    bif.bus_rdata = '0;
    drive_masters();
    do_reset("rst0");

    // Single CPU read, ready in the second XFER cycle.
    slave_delay = 1;
    base = cyc + 1;
    add_tx(0, 32'h0000_1004, 1'b1, 4'h0, 1'b0, 1'b0, base + 4);
    step();
    step();
    chk("t1_gnt", 64'(bif.m_gnt), 64'(2'b01));
    chk("t1_busy", 64'(busy), 64'(1));
    run_done(50);

    // Contention with immediate ready: grants alternate 0,1,0,1.
    do_reset("rst2");
    slave_delay = 0;
    base = cyc + 1;
    add_tx(0, 32'h0000_0100, 1'b1, 4'h0, 1'b0, 1'b0, base + 3);
    add_tx(1, 32'h0000_0200, 1'b1, 4'h0, 1'b0, 1'b0, base + 6);
    add_tx(0, 32'h0000_0104, 1'b0, 4'hF, 1'b0, 1'b0, base + 9);
    add_tx(1, 32'h0000_0204, 1'b1, 4'h0, 1'b0, 1'b0, base + 12);
    run_done(100);

    // Locked burst of three from master 1 while master 0 waits.
    do_reset("rst3");
    slave_delay = 0;
    base = cyc + 1;
    add_tx(1, 32'h0000_0300, 1'b1, 4'h0, 1'b1, 1'b0, base + 3);
    add_tx(1, 32'h0000_0304, 1'b0, 4'h3, 1'b1, 1'b0, base + 5);
    add_tx(1, 32'h0000_0308, 1'b1, 4'h0, 1'b0, 1'b0, base + 7);
    step();
    add_tx(0, 32'h0000_0400, 1'b1, 4'h0, 1'b0, 1'b0, base + 10);
    run_done(100);

    // Timeout: ready never comes, error after counter reaches 4.
    do_reset("rst4");
    slave_delay = 255;
    base = cyc + 1;
    add_tx(0, 32'h0000_0500, 1'b1, 4'h0, 1'b1, 1'b1, base + 7);
    run_done(50);

    // Ready on the expiry cycle wins over the timeout.
    do_reset("rst5");
    slave_delay = 4;
    base = cyc + 1;
    add_tx(0, 32'h0000_0600, 1'b1, 4'h0, 1'b0, 1'b0, base + 7);
    run_done(50);

    // Reset mid-write restores the parked priority pointer.
    do_reset("rst6");
    slave_delay = 0;
    base = cyc + 1;
    add_tx(0, 32'h0000_0700, 1'b1, 4'h0, 1'b0, 1'b0, base + 3);
    run_done(50);
    slave_delay = 255;
    add_tx(1, 32'h0000_0800, 1'b0, 4'hF, 1'b0, 1'b0, -1);
    step();
    step();
    step();
    chk("t6_we_live", 64'(bif.bus_we), 64'(4'hF));
    chk("t6_addr_live", 64'(bif.bus_addr), 64'(32'h0000_0800));
    rst = 1'b1;
    mq1.delete();
    drive_masters();
    step();
    chk("t6_we_cut", 64'(bif.bus_we), 64'(0));
    chk("t6_gnt_cut", 64'(bif.m_gnt), 64'(0));
    chk("t6_busy_cut", 64'(busy), 64'(0));
    rst = 1'b0;
    model_rdata = '0;
    slave_delay = 0;
    step();
    base = cyc + 1;
    add_tx(0, 32'h0000_0900, 1'b1, 4'h0, 1'b0, 1'b0, base + 3);
    add_tx(1, 32'h0000_0A00, 1'b1, 4'h0, 1'b0, 1'b0, base + 6);
    run_done(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
